// File: rtl/regfile_access_arbiter_pkg.sv
// Shared types and constants for the register-file access arbiter.
// Requester indices, arbiter states and the latched request format.
package regfile_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int NUM_REQ = 2;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_CAPTURE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] ra1;
        logic [ADDR_W-1:0] ra2;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
    } rf_req_t;

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/regfile_access_arbiter_if.sv
// Requester-side bus of the register-file arbiter: per-requester request
// fields, one-hot ready, one-hot response strobe and shared read data.
interface regfile_access_arbiter_if;
    import regfile_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] req_we;
    logic [ADDR_W-1:0]  req_ra1_0;
    logic [ADDR_W-1:0]  req_ra1_1;
    logic [ADDR_W-1:0]  req_ra2_0;
    logic [ADDR_W-1:0]  req_ra2_1;
    logic [ADDR_W-1:0]  req_wa_0;
    logic [ADDR_W-1:0]  req_wa_1;
    logic [DATA_W-1:0]  req_wd_0;
    logic [DATA_W-1:0]  req_wd_1;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [DATA_W-1:0]  rsp_rd1;
    logic [DATA_W-1:0]  rsp_rd2;

    modport master (
        output req_valid, req_we, req_ra1_0, req_ra1_1, req_ra2_0, req_ra2_1,
               req_wa_0, req_wa_1, req_wd_0, req_wd_1,
        input  req_ready, rsp_valid, rsp_rd1, rsp_rd2
    );

    modport slave (
        input  req_valid, req_we, req_ra1_0, req_ra1_1, req_ra2_0, req_ra2_1,
               req_wa_0, req_wa_1, req_wd_0, req_wd_1,
        output req_ready, rsp_valid, rsp_rd1, rsp_rd2
    );

endinterface

// File: rtl/regfile_access_arbiter_grant_sel.sv
// Combinational winner pick between core and debug, plus the next value of
// the starvation counter that guards debug against a busy core.
module regfile_grant_sel
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [CNT_W-1:0]   starve_cnt,
    output logic               any,
    output logic               winner,
    output logic [CNT_W-1:0]   starve_nxt
);

    logic at_limit;

    assign at_limit = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign any      = |valid;

    always_comb begin
        winner = REQ_CORE;
        if (valid == 2'b10)
            winner = REQ_DBG;
        else if (valid == 2'b11 && at_limit)
            winner = REQ_DBG;
    end

    // Only a core win over a waiting debug request counts toward starvation.
    always_comb begin
        starve_nxt = '0;
        if (winner == REQ_CORE && valid[REQ_DBG])
            starve_nxt = at_limit ? starve_cnt : starve_cnt + 1'b1;
    end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares one register file between core and debug: one access per three
// cycles (IDLE -> ISSUE -> CAPTURE), read data returned with a one-cycle strobe.
module regfile_access_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter bit ZERO_PROTECT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_access_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0]        rf_read_reg1,
    output logic [ADDR_W-1:0]        rf_read_reg2,
    output logic [ADDR_W-1:0]        rf_write_reg,
    output logic                     rf_write_flag,
    output logic [DATA_W-1:0]        rf_data,
    input  logic [DATA_W-1:0]        rf_read_data1,
    input  logic [DATA_W-1:0]        rf_read_data2
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e         state;
    rf_req_t            lat;
    rf_req_t            sel_req;
    logic               win_q;
    logic [CNT_W-1:0]   starve_cnt;
    logic [CNT_W-1:0]   starve_nxt;
    logic               any;
    logic               winner;
    logic               handshake;
    logic               write_ok;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_rd1_q;
    logic [DATA_W-1:0]  rsp_rd2_q;

    regfile_grant_sel #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_grant_sel (
        .valid      (bus.req_valid),
        .starve_cnt (starve_cnt),
        .any        (any),
        .winner     (winner),
        .starve_nxt (starve_nxt)
    );

    always_comb begin
        if (winner == REQ_DBG)
            sel_req = '{we: bus.req_we[REQ_DBG], ra1: bus.req_ra1_1, ra2: bus.req_ra2_1,
                        wa: bus.req_wa_1, wd: bus.req_wd_1};
        else
            sel_req = '{we: bus.req_we[REQ_CORE], ra1: bus.req_ra1_0, ra2: bus.req_ra2_0,
                        wa: bus.req_wa_0, wd: bus.req_wd_0};
    end

    // Ready is offered only in IDLE, so a requester that drops valid while
    // an access is in flight never reaches a handshake.
    assign bus.req_ready = (state == ARB_IDLE && any) ? req_onehot(winner) : '0;
    assign handshake     = |(bus.req_valid & bus.req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            lat         <= '0;
            win_q       <= REQ_CORE;
            starve_cnt  <= '0;
            rsp_valid_q <= '0;
            rsp_rd1_q   <= '0;
            rsp_rd2_q   <= '0;
        end else begin
            rsp_valid_q <= '0;
            case (state)
                ARB_IDLE: begin
                    if (handshake) begin
                        lat        <= sel_req;
                        win_q      <= winner;
                        starve_cnt <= starve_nxt;
                        state      <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    state <= ARB_CAPTURE;
                end
                ARB_CAPTURE: begin
                    rsp_rd1_q   <= rf_read_data1;
                    rsp_rd2_q   <= rf_read_data2;
                    rsp_valid_q <= req_onehot(win_q);
                    state       <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Register 0 is hard-wired zero when protected; the write is simply not issued.
    assign write_ok = lat.we & ~(ZERO_PROTECT & (lat.wa == '0));

    assign rf_read_reg1  = lat.ra1;
    assign rf_read_reg2  = lat.ra2;
    assign rf_write_reg  = lat.wa;
    assign rf_data       = lat.wd;
    assign rf_write_flag = (state == ARB_ISSUE) & write_ok;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rd1   = rsp_rd1_q;
    assign bus.rsp_rd2   = rsp_rd2_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Randomized bench for regfile_access_arbiter: a behavioural register file
// drives the DUT, a shadow array and an arbitration model predict responses.
module tb_regfile_access_arbiter;
    import regfile_pkg::*;

    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_access_arbiter_if ifc ();

    logic [ADDR_W-1:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
    logic              rf_write_flag;
    logic [DATA_W-1:0] rf_data, rf_read_data1, rf_read_data2;

    regfile_access_arbiter #(.STARVE_LIMIT(LIM), .ZERO_PROTECT(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (ifc.slave),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_write_reg  (rf_write_reg),
        .rf_write_flag (rf_write_flag),
        .rf_data       (rf_data),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2)
    );

    // Register file with registered reads; not cleared by the arbiter reset.
    logic [DATA_W-1:0] rf_mem [32];
    logic              rf_clr;
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
        end else if (rf_write_flag) begin
            rf_mem[rf_write_reg] <= rf_data;
        end
        rf_read_data1 <= rf_mem[rf_read_reg1];
        rf_read_data2 <= rf_mem[rf_read_reg2];
    end

    int total = 0;
    int bad   = 0;
    int cnt_m = 0;
    int last_w;
    logic [DATA_W-1:0] ref_mem [32];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return (cnt_m == LIM) ? 1 : 0;
    endfunction

    task automatic set_req(input int r, input logic we, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [4:0] wa, input logic [31:0] wd);
        if (r == 0) begin
            ifc.req_we[0] = we; ifc.req_ra1_0 = a1; ifc.req_ra2_0 = a2;
            ifc.req_wa_0 = wa;  ifc.req_wd_0 = wd;
        end else begin
            ifc.req_we[1] = we; ifc.req_ra1_1 = a1; ifc.req_ra2_1 = a2;
            ifc.req_wa_1 = wa;  ifc.req_wd_1 = wd;
        end
    endtask

    task automatic rand_req();
        for (int r = 0; r < 2; r++)
            set_req(r, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    endtask

    task automatic idle(input int n);
        ifc.req_valid = 2'b00;
        repeat (n) begin
            @(negedge clk); #1;
            chk("idle_ready", ifc.req_ready, 2'b00);
            chk("idle_rsp", ifc.rsp_valid, 2'b00);
        end
    endtask

    // Called just after a negedge with the DUT idle; returns three cycles later.
    task automatic access(input logic [1:0] vld, input bit abort, input bit glitch);
        int w;
        logic [1:0] eg;
        logic [4:0] a1, a2, wa;
        logic [31:0] wd, e1, e2;
        logic we, ewe;
        ifc.req_valid = vld;
        #1;
        w  = pick(vld);
        eg = (w == 1) ? 2'b10 : 2'b01;
        chk("grant", ifc.req_ready, eg);
        last_w = (ifc.req_ready == 2'b10) ? 1 : 0;
        cnt_m  = (w == 0 && vld[1]) ? ((cnt_m < LIM) ? cnt_m + 1 : LIM) : 0;
        if (w == 1) begin
            we = ifc.req_we[1]; a1 = ifc.req_ra1_1; a2 = ifc.req_ra2_1; wa = ifc.req_wa_1; wd = ifc.req_wd_1;
        end else begin
            we = ifc.req_we[0]; a1 = ifc.req_ra1_0; a2 = ifc.req_ra2_0; wa = ifc.req_wa_0; wd = ifc.req_wd_0;
        end
        e1  = ref_mem[a1];
        e2  = ref_mem[a2];
        ewe = we && (wa != 5'd0);
        @(negedge clk); #1;
        chk("issue_wflag", rf_write_flag, ewe);
        chk("issue_ra1", rf_read_reg1, a1);
        chk("issue_ra2", rf_read_reg2, a2);
        chk("issue_ready", ifc.req_ready, 2'b00);
        if (ewe) begin
            chk("issue_wa", rf_write_reg, wa);
            chk("issue_wd", rf_data, wd);
        end
        if (glitch) ifc.req_valid[1] = 1'b1;
        if (abort) begin
            ifc.req_valid = 2'b00;
            rst_n = 1'b0;
            #1;
            chk("rst_wflag", rf_write_flag, 1'b0);
            chk("rst_rsp", ifc.rsp_valid, 2'b00);
            chk("rst_ready", ifc.req_ready, 2'b00);
            chk("rst_rd1", ifc.rsp_rd1, 32'h0);
            chk("rst_ra1", rf_read_reg1, 5'h0);
            chk("rst_data", rf_data, 32'h0);
            @(negedge clk);
            chk("rst_rsp_hold", ifc.rsp_valid, 2'b00);
            rst_n = 1'b1;
            cnt_m = 0;
            return;
        end
        if (ewe) ref_mem[wa] = wd;
        @(negedge clk); #1;
        chk("capt_rsp", ifc.rsp_valid, 2'b00);
        chk("capt_wflag", rf_write_flag, 1'b0);
        if (glitch) ifc.req_valid[1] = 1'b0;
        @(negedge clk); #1;
        chk("rsp_valid", ifc.rsp_valid, eg);
        chk("rsp_rd1", ifc.rsp_rd1, e1);
        chk("rsp_rd2", ifc.rsp_rd2, e2);
    endtask

    int t3_exp [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int t5_exp [5]  = '{0, 0, 0, 0, 1};

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        rst_n = 1'b0;
        rf_clr = 1'b1;
        ifc.req_valid = 2'b00;
        set_req(0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        set_req(1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ready", ifc.req_ready, 2'b00);
        chk("reset_rsp", ifc.rsp_valid, 2'b00);
        chk("reset_wflag", rf_write_flag, 1'b0);
        chk("reset_rd1", ifc.rsp_rd1, 32'h0);
        chk("reset_rd2", ifc.rsp_rd2, 32'h0);
        chk("reset_ra1", rf_read_reg1, 5'h0);
        chk("reset_data", rf_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rf_clr = 1'b0;

        // core write then read back
        set_req(0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
        access(2'b01, 1'b0, 1'b0);
        set_req(0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0);
        access(2'b01, 1'b0, 1'b0);
        chk("t1_rd1", ifc.rsp_rd1, 32'hDEADBEEF);

        // debug write to r0 is suppressed
        set_req(1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1234);
        access(2'b10, 1'b0, 1'b0);
        set_req(1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        access(2'b10, 1'b0, 1'b0);
        chk("t2_rd1", ifc.rsp_rd1, 32'h0);

        // read-during-write returns the old value
        set_req(0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h11);
        access(2'b01, 1'b0, 1'b0);
        set_req(0, 1'b1, 5'd7, 5'd7, 5'd7, 32'hA5);
        access(2'b01, 1'b0, 1'b0);
        chk("t4_old", ifc.rsp_rd1, 32'h11);
        set_req(0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0);
        access(2'b01, 1'b0, 1'b0);
        chk("t4_new", ifc.rsp_rd1, 32'hA5);

        // both requesters continuously valid
        for (int i = 0; i < 10; i++) begin
            rand_req();
            access(2'b11, 1'b0, 1'b0);
            chk("t3_grant_seq", last_w, t3_exp[i]);
        end

        // debug pulses valid while core is busy
        idle(1);
        rand_req();
        access(2'b01, 1'b0, 1'b1);
        idle(3);

        // reset during ISSUE, then starvation counter starts over
        rand_req();
        access(2'b11, 1'b0, 1'b0);
        rand_req();
        access(2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            rand_req();
            access(2'b11, 1'b0, 1'b0);
            chk("t5_grant_seq", last_w, t5_exp[i]);
        end

        // random traffic
        for (int i = 0; i < 200; i++) begin
            rand_req();
            if ($urandom_range(0, 7) == 0) idle(1);
            access(2'($urandom_range(1, 3)), ($urandom_range(0, 29) == 0), 1'b0);
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
